// File: rtl/adc_xy_fb_writer.sv
// adc_xy_fb_writer: decimating, clipping XY-to-framebuffer write stage with full-frame clear sweep.
// Optional ADC_XY_FB_WRITER_DEDUP_EN suppresses writes identical to the last emitted RUN write.
module adc_xy_fb_writer #(
    parameter int ADC_DATA_BITS = 10,
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int ADDR_BITS     = 20,
    parameter int PIXEL_BITS    = 12,
    parameter int META_BITS     = 4,
    parameter int DEC_BITS      = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [ADC_DATA_BITS-1:0]        s_x,
    input  logic [ADC_DATA_BITS-1:0]        s_y,
    input  logic [ADC_DATA_BITS-1:0]        x_offset,
    input  logic [ADC_DATA_BITS-1:0]        y_offset,
    input  logic [DEC_BITS-1:0]             decimate,
    input  logic [PIXEL_BITS-1:0]           color,
    input  logic                            frame_tick,
    input  logic                            clear_req,
    output logic                            clearing,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [ADDR_BITS-1:0]            m_addr,
    output logic [META_BITS+PIXEL_BITS-1:0] m_data,
    output logic [15:0]                     clip_count
);
    localparam int DW = ADC_DATA_BITS + 1;
    localparam int AW1 = ADDR_BITS + 1;
    localparam int DATA_W = META_BITS + PIXEL_BITS;
    localparam logic [DW-1:0] H_LIM = DW'(H_VISIBLE);
    localparam logic [DW-1:0] V_LIM = DW'(V_VISIBLE);
    localparam logic [ADDR_BITS-1:0] H_MUL = ADDR_BITS'(H_VISIBLE);
    localparam logic [ADDR_BITS:0] N_PIX = AW1'(H_VISIBLE * V_VISIBLE);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    state_t state, state_nx;

    logic                     adv, accept, keep, in_win, dup;
    logic [DW-1:0]            dx, dy;
    logic [META_BITS-1:0]     tag;
    logic [DEC_BITS-1:0]      dec_cnt;
    logic                     v0, v1;
    logic [ADC_DATA_BITS-1:0] dx0, dy0, dx1;
    logic [DATA_W-1:0]        d0, d1;
    logic [ADDR_BITS-1:0]     row1, addr1;
    logic [ADDR_BITS:0]       clr_cnt;

    assign adv      = !m_valid || m_ready;
    assign s_ready  = adv && state == RUN;
    assign accept   = s_valid && s_ready;
    assign keep     = dec_cnt == decimate;
    assign clearing = state != RUN;
    // Differences are taken one bit wider so a negative result shows up as the top bit.
    assign dx       = {1'b0, s_x} - {1'b0, x_offset};
    assign dy       = {1'b0, s_y} - {1'b0, y_offset};
    assign in_win   = !dx[DW-1] && !dy[DW-1] && dx < H_LIM && dy < V_LIM;
    assign addr1    = row1 + ADDR_BITS'(dx1);

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = clear_req ? DRAIN : RUN;
            DRAIN:   state_nx = (!v0 && !v1 && !m_valid) ? CLEAR : DRAIN;
            CLEAR:   state_nx = (m_valid && m_ready && clr_cnt == N_PIX) ? RUN : CLEAR;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            tag        <= '0;
            dec_cnt    <= '0;
            clip_count <= '0;
            clr_cnt    <= '0;
            v0         <= 1'b0;
            dx0        <= '0;
            dy0        <= '0;
            d0         <= '0;
            v1         <= 1'b0;
            row1       <= '0;
            dx1        <= '0;
            d1         <= '0;
            m_valid    <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
        end else begin
            state <= state_nx;
            if (frame_tick)
                tag <= tag + 1'b1;
            if (state == CLEAR && state_nx == RUN)
                dec_cnt <= '0;
            else if (accept)
                dec_cnt <= keep ? '0 : dec_cnt + 1'b1;
            if (accept && keep && !in_win && clip_count != '1)
                clip_count <= clip_count + 16'd1;
            if (state != CLEAR)
                clr_cnt <= '0;
            else if (adv && clr_cnt != N_PIX)
                clr_cnt <= clr_cnt + 1'b1;
            if (adv) begin
                v0   <= accept && keep && in_win;
                dx0  <= dx[ADC_DATA_BITS-1:0];
                dy0  <= dy[ADC_DATA_BITS-1:0];
                d0   <= {tag, color};
                v1   <= v0;
                row1 <= ADDR_BITS'(dy0) * H_MUL;
                dx1  <= dx0;
                d1   <= d0;
                // The clear sweep owns the output register; the sample pipeline is empty then.
                if (state == CLEAR) begin
                    m_valid <= clr_cnt != N_PIX;
                    m_addr  <= clr_cnt[ADDR_BITS-1:0];
                    m_data  <= '0;
                end else begin
                    m_valid <= v1 && !dup;
                    m_addr  <= addr1;
                    m_data  <= d1;
                end
            end
        end
    end

`ifdef ADC_XY_FB_WRITER_DEDUP_EN
    logic                 last_v;
    logic [ADDR_BITS-1:0] last_addr;
    logic [DATA_W-1:0]    last_data;

    assign dup = last_v && last_addr == addr1 && last_data == d1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_v    <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
        end else if (frame_tick || state == CLEAR) begin
            last_v <= 1'b0;
        end else if (adv && v1) begin
            last_v    <= 1'b1;
            last_addr <= addr1;
            last_data <= d1;
        end
    end
`else
    assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_adc_xy_fb_writer.sv
// tb_adc_xy_fb_writer: directed vector bench; a 640x480 instance for the data path and a 4x3 instance for the clear sweep.
module tb_adc_xy_fb_writer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid_b, s_valid_s;
    logic [9:0]  s_x, s_y, x_offset, y_offset;
    logic [7:0]  decimate;
    logic [11:0] color;
    logic        frame_tick, clear_req_b, clear_req_s, m_ready;
    logic        s_ready_b, clearing_b, m_valid_b;
    logic        s_ready_s, clearing_s, m_valid_s;
    logic [19:0] m_addr_b, m_addr_s;
    logic [15:0] m_data_b, m_data_s, clip_b, clip_s;

    int total = 0;
    int bad = 0;
    logic [3:0] tag_e = 4'd0;
    logic [19:0] qa_b[$], qa_s[$];
    logic [15:0] qd_b[$], qd_s[$];

    always #5 clk = ~clk;

    adc_xy_fb_writer dut_b (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_x(s_x), .s_y(s_y), .x_offset(x_offset), .y_offset(y_offset),
        .decimate(decimate), .color(color), .frame_tick(frame_tick), .clear_req(clear_req_b),
        .clearing(clearing_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_addr(m_addr_b), .m_data(m_data_b), .clip_count(clip_b)
    );

    adc_xy_fb_writer #(.H_VISIBLE(4), .V_VISIBLE(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid_s), .s_ready(s_ready_s),
        .s_x(s_x), .s_y(s_y), .x_offset(x_offset), .y_offset(y_offset),
        .decimate(decimate), .color(color), .frame_tick(frame_tick), .clear_req(clear_req_s),
        .clearing(clearing_s), .m_valid(m_valid_s), .m_ready(m_ready),
        .m_addr(m_addr_s), .m_data(m_data_s), .clip_count(clip_s)
    );

    always @(negedge clk) begin
        if (m_valid_b && m_ready) begin
            qa_b.push_back(m_addr_b);
            qd_b.push_back(m_data_b);
        end
        if (m_valid_s && m_ready) begin
            qa_s.push_back(m_addr_s);
            qd_s.push_back(m_data_s);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int x, input int y);
        s_valid_b = 1'b1;
        s_x = 10'(x);
        s_y = 10'(y);
        step();
        s_valid_b = 1'b0;
        step();
        step();
    endtask

    typedef struct {
        int x, y, xo, yo;
        bit v;
        int addr;
    } vec_t;

    vec_t vt[8];
    int clip_e = 0;
    int n;

    initial begin
        vt[0] = '{5, 2, 0, 0, 1'b1, 1285};
        vt[1] = '{639, 479, 0, 0, 1'b1, 307199};
        vt[2] = '{0, 0, 0, 0, 1'b1, 0};
        vt[3] = '{50, 0, 100, 0, 1'b0, 0};
        vt[4] = '{740, 0, 100, 0, 1'b0, 0};
        vt[5] = '{150, 10, 100, 5, 1'b1, 3250};
        vt[6] = '{3, 480, 0, 0, 1'b0, 0};
        vt[7] = '{0, 0, 0, 1, 1'b0, 0};

        reset_n = 1'b0;
        s_valid_b = 1'b0; s_valid_s = 1'b0;
        s_x = '0; s_y = '0; x_offset = '0; y_offset = '0;
        decimate = '0; color = 12'hABC; frame_tick = 1'b0;
        clear_req_b = 1'b0; clear_req_s = 1'b0; m_ready = 1'b1;
        repeat (3) step();
        chk("rst_m_valid", 32'(m_valid_b), 0);
        chk("rst_m_addr", 32'(m_addr_b), 0);
        chk("rst_m_data", 32'(m_data_b), 0);
        chk("rst_clearing", 32'(clearing_b), 0);
        chk("rst_clip", 32'(clip_b), 0);
        reset_n = 1'b1;
        step();
        chk("rst_s_ready", 32'(s_ready_b), 1);

        for (int i = 0; i < 8; i++) begin
            x_offset = 10'(vt[i].xo);
            y_offset = 10'(vt[i].yo);
            send(vt[i].x, vt[i].y);
            if (!vt[i].v) clip_e++;
            chk($sformatf("vec%0d_valid", i), 32'(m_valid_b), 32'(vt[i].v));
            if (vt[i].v) begin
                chk($sformatf("vec%0d_addr", i), 32'(m_addr_b), vt[i].addr);
                chk($sformatf("vec%0d_data", i), 32'(m_data_b), 32'({tag_e, color}));
            end
            chk($sformatf("vec%0d_clip", i), 32'(clip_b), clip_e);
            step();
        end

        x_offset = '0;
        y_offset = '0;
        decimate = 8'd2;
        qa_b.delete();
        qd_b.delete();
        for (int i = 1; i <= 9; i++) begin
            s_valid_b = 1'b1;
            s_x = 10'(i);
            s_y = '0;
            step();
        end
        s_valid_b = 1'b0;
        repeat (6) step();
        chk("dec_count", qa_b.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("dec_addr%0d", k), k < qa_b.size() ? 32'(qa_b[k]) : 32'hFFFFFFFF, 3 * (k + 1));
        decimate = '0;

        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid_b = 1'b1;
            s_x = 10'(20 + i);
            s_y = 10'd1;
            step();
        end
        s_valid_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("stall_s_ready", 32'(s_ready_b), 0);
            chk("stall_m_valid", 32'(m_valid_b), 1);
            chk("stall_addr", 32'(m_addr_b), 660);
            chk("stall_data", 32'(m_data_b), 32'({tag_e, color}));
            step();
        end
        qa_b.delete();
        qd_b.delete();
        m_ready = 1'b1;
        repeat (6) step();
        chk("drain_count", qa_b.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain_addr%0d", k), k < qa_b.size() ? 32'(qa_b[k]) : 32'hFFFFFFFF, 660 + k);

        frame_tick = 1'b1;
        repeat (17) step();
        frame_tick = 1'b0;
        tag_e = 4'd1;
        send(5, 2);
        chk("tag_valid", 32'(m_valid_b), 1);
        chk("tag_addr", 32'(m_addr_b), 1285);
        chk("tag_data", 32'(m_data_b), 32'h1ABC);
        step();

        qa_b.delete();
        qd_b.delete();
        s_valid_b = 1'b1;
        s_x = 10'd7;
        s_y = 10'd3;
        step();
        step();
        s_valid_b = 1'b0;
        repeat (6) step();
`ifdef ADC_XY_FB_WRITER_DEDUP_EN
        chk("dedup_count", qa_b.size(), 1);
`else
        chk("dedup_count", qa_b.size(), 2);
`endif
        chk("dedup_addr", qa_b.size() > 0 ? 32'(qa_b[0]) : 32'hFFFFFFFF, 1927);

        qa_s.delete();
        qd_s.delete();
        s_valid_s = 1'b1;
        s_x = 10'd1;
        s_y = 10'd1;
        step();
        s_x = 10'd3;
        s_y = 10'd2;
        clear_req_s = 1'b1;
        step();
        s_valid_s = 1'b0;
        clear_req_s = 1'b0;
        chk("clr_clearing", 32'(clearing_s), 1);
        chk("clr_s_ready", 32'(s_ready_s), 0);
        n = 0;
        while (clearing_s && n < 80) begin
            step();
            n++;
        end
        chk("clr_done", 32'(clearing_s), 0);
        chk("clr_s_ready_back", 32'(s_ready_s), 1);
        chk("clr_count", qa_s.size(), 14);
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("clr_addr%0d", k), k < qa_s.size() ? 32'(qa_s[k]) : 32'hFFFFFFFF,
                k == 0 ? 5 : k == 1 ? 11 : k - 2);
            chk($sformatf("clr_data%0d", k), k < qd_s.size() ? 32'(qd_s[k]) : 32'hFFFFFFFF,
                k < 2 ? 32'h1ABC : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
